// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: captures ALU result/control, owns the Z/N flags, resolves branches, feeds EX->EX forwarding.
// Latency: 1 cycle EX->MEM; branch_taken is a one-cycle pulse on the edge that accepts the branch.
// Backpressure: single entry, no skid; ex_ready = !mem_valid | mem_ready, so a stalled MEM stalls EX combinationally.
//
// Ports:
//   clk, reset (async, active-high), flush
//   EX side : ex_valid/ex_ready, alu_result, alu_op, zero_flag, negative_flag, ex_rd,
//             ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_branch, ex_cond
//   MEM side: mem_valid/mem_ready, mem_alu_result, mem_rd, mem_reg_write, mem_mem_read,
//             mem_mem_write, mem_store_data
//   Status  : flag_z, flag_n, branch_taken, fwd_valid, fwd_rd, fwd_data
module ex_mem_stage #(
  parameter int N    = 32,
  parameter int RD_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [N-1:0]    alu_result,
  input  logic [1:0]      alu_op,
  input  logic            zero_flag,
  input  logic            negative_flag,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [N-1:0]    ex_store_data,
  input  logic            ex_branch,
  input  logic [1:0]      ex_cond,
  input  logic            mem_ready,
  output logic            mem_valid,
  output logic [N-1:0]    mem_alu_result,
  output logic [RD_W-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [N-1:0]    mem_store_data,
  output logic            flag_z,
  output logic            flag_n,
  output logic            branch_taken,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [N-1:0]    fwd_data
);

  localparam logic [1:0] OP_CMP = 2'b11;

  logic accept;
  logic cond_true;

  assign ex_ready = !mem_valid || mem_ready;
  // Flush wins over a valid instruction: the input is consumed but dropped.
  assign accept   = ex_valid && ex_ready && !flush;

  // Evaluated against the flags currently held, so a CMP+branch in one
  // instruction sees the flags from before that CMP.
  always_comb begin
    cond_true = 1'b0;
    case (ex_cond)
      2'b00:   cond_true = flag_z;
      2'b01:   cond_true = !flag_z;
      2'b10:   cond_true = flag_n;
      default: cond_true = !flag_n;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
      flag_z         <= 1'b0;
      flag_n         <= 1'b0;
      branch_taken   <= 1'b0;
    end else begin
      // Pulse only on the accepting edge; a stall never re-asserts it.
      branch_taken <= accept && ex_branch && cond_true;
      if (flush) begin
        mem_valid <= 1'b0;
      end else if (accept) begin
        mem_valid      <= 1'b1;
        mem_alu_result <= alu_result;
        mem_rd         <= ex_rd;
        mem_reg_write  <= ex_reg_write;
        mem_mem_read   <= ex_mem_read;
        mem_mem_write  <= ex_mem_write;
        mem_store_data <= ex_store_data;
        // ALU flags are only defined for CMP.
        if (alu_op == OP_CMP) begin
          flag_z <= zero_flag;
          flag_n <= negative_flag;
        end
      end else if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end

  // Loads have no data yet in this stage, and r0 is never a forwarding target.
  assign fwd_valid = mem_valid && mem_reg_write && !mem_mem_read && (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_result;

endmodule
